// File: rtl/icache_if.sv
// icache bus bundle: IF-side fetch port (mem_*) and line-fill port (pmem_*).
// slave = cache side, master = IF stage plus physical memory side.
interface icache_if;
  logic [31:0]  mem_address;
  logic         mem_read;
  logic [31:0]  mem_rdata;
  logic         mem_resp;
  logic [31:0]  pmem_address;
  logic         pmem_read;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  modport slave (
    input  mem_address, mem_read,
    output mem_rdata, mem_resp,
    output pmem_address, pmem_read,
    input  pmem_rdata, pmem_resp
  );

  modport master (
    output mem_address, mem_read,
    input  mem_rdata, mem_resp,
    input  pmem_address, pmem_read,
    output pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/icache.sv
// icache: read-only 2-way set-associative I-cache, 256-bit lines, LRU.
// Ports: clk, rst (sync, active-high), bus (icache_if.slave).
// Optional: ICACHE_FILL_FORWARD_EN forwards fill data in the pmem_resp cycle.
module icache #(
  parameter int s_index  = 3,
  parameter int s_offset = 5
) (
  input  logic      clk,
  input  logic      rst,
  icache_if.slave   bus
);
  localparam int TAG_W = 32 - s_offset - s_index;
  localparam int SETS  = 1 << s_index;
  localparam int LINE_W = 32 - s_offset;

  typedef enum logic {IDLE, FILL} state_t;

  state_t state, state_n;

  logic [TAG_W-1:0]    tag;
  logic [s_index-1:0]  idx;
  logic [s_offset-3:0] word;

  logic [1:0]       valid_q [SETS];
  logic [TAG_W-1:0] tag_q   [SETS][2];
  logic [255:0]     data_q  [SETS][2];
  logic [SETS-1:0]  lru_q;

  logic [LINE_W-1:0]  miss_line;
  logic               victim_q;
  logic [s_index-1:0] miss_idx;
  logic [TAG_W-1:0]   miss_tag;

`ifdef ICACHE_FILL_FORWARD_EN
  logic [s_offset-3:0] miss_word;
`endif

  logic         hit0, hit1, hit, miss;
  logic         hit_way, victim_n, fill_done;
  logic [255:0] hit_line;
  logic [7:0]   word_bit;

  assign tag  = bus.mem_address[31 -: TAG_W];
  assign idx  = bus.mem_address[s_offset +: s_index];
  assign word = bus.mem_address[s_offset-1:2];
  assign word_bit = 8'({word, 5'b0});

  assign miss_idx = miss_line[s_index-1:0];
  assign miss_tag = miss_line[s_index +: TAG_W];

  assign hit0 = valid_q[idx][0] && (tag_q[idx][0] == tag);
  assign hit1 = valid_q[idx][1] && (tag_q[idx][1] == tag);
  assign hit  = (state == IDLE) && bus.mem_read && (hit0 || hit1);
  assign miss = (state == IDLE) && bus.mem_read && !(hit0 || hit1);

  // Both ways never hold the same line, so way 0 priority is safe.
  assign hit_way  = !hit0;
  assign hit_line = data_q[idx][hit_way];

  // Fill invalid ways first, way 0 before way 1, then the LRU way.
  assign victim_n = !valid_q[idx][0] ? 1'b0 :
                    !valid_q[idx][1] ? 1'b1 : lru_q[idx];

  assign fill_done = (state == FILL) && bus.pmem_resp;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (miss) state_n = FILL;
      FILL: if (bus.pmem_resp) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_resp     = 1'b0;
    bus.mem_rdata    = '0;
    bus.pmem_read    = 1'b0;
    bus.pmem_address = '0;
    unique case (state)
      IDLE: begin
        if (hit) begin
          bus.mem_resp  = 1'b1;
          bus.mem_rdata = hit_line[word_bit +: 32];
        end
      end
      FILL: begin
        bus.pmem_read    = 1'b1;
        bus.pmem_address = {miss_line, {s_offset{1'b0}}};
`ifdef ICACHE_FILL_FORWARD_EN
        if (bus.pmem_resp && bus.mem_read) begin
          bus.mem_resp  = 1'b1;
          bus.mem_rdata = bus.pmem_rdata[8'({miss_word, 5'b0}) +: 32];
        end
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lru_q <= '0;
      for (int s = 0; s < SETS; s++) valid_q[s] <= 2'b00;
    end else begin
      if (hit) lru_q[idx] <= ~hit_way;
      if (fill_done) begin
        valid_q[miss_idx][victim_q] <= 1'b1;
        lru_q[miss_idx] <= ~victim_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (miss) begin
      miss_line <= bus.mem_address[31:s_offset];
      victim_q  <= victim_n;
`ifdef ICACHE_FILL_FORWARD_EN
      miss_word <= word;
`endif
    end
    if (fill_done) begin
      tag_q[miss_idx][victim_q]  <= miss_tag;
      data_q[miss_idx][victim_q] <= bus.pmem_rdata;
    end
  end
endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache.
// Memory word at byte address a reads as 32'hA500_0000 | a.
module tb_icache;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int errs = 0;

  icache_if bus ();

  icache dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] line_of(input logic [31:0] la);
    logic [255:0] l;
    for (int k = 0; k < 8; k++)
      l[k*32 +: 32] = 32'hA500_0000 | (la + 32'(k * 4));
    return l;
  endfunction

  task automatic check(input string t, input logic [31:0] o,
                       input logic [31:0] e);
    vectors++;
    assert (o === e) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", t, o, e);
    end
  endtask

  task automatic hit_read(input logic [31:0] a, input logic [31:0] e,
                          input string t);
    @(negedge clk);
    bus.mem_address = a;
    bus.mem_read = 1'b1;
    #1;
    check({t, ":resp"}, 32'(bus.mem_resp), 32'd1);
    check({t, ":rdata"}, bus.mem_rdata, e);
    check({t, ":pread"}, 32'(bus.pmem_read), 32'd0);
    @(negedge clk);
    bus.mem_read = 1'b0;
  endtask

  task automatic miss_fill(input logic [31:0] a, input int lat,
                           input logic [31:0] e, input string t);
    logic [31:0] la;
    la = {a[31:5], 5'b0};
    @(negedge clk);
    bus.mem_address = a;
    bus.mem_read = 1'b1;
    #1;
    check({t, ":miss_resp"}, 32'(bus.mem_resp), 32'd0);
    check({t, ":miss_pread"}, 32'(bus.pmem_read), 32'd0);
    @(negedge clk);
    #1;
    check({t, ":pread"}, 32'(bus.pmem_read), 32'd1);
    check({t, ":paddr"}, bus.pmem_address, la);
    repeat (lat - 1) @(negedge clk);
    bus.pmem_resp = 1'b1;
    bus.pmem_rdata = line_of(la);
    #1;
`ifdef ICACHE_FILL_FORWARD_EN
    check({t, ":fwd_resp"}, 32'(bus.mem_resp), 32'd1);
    check({t, ":fwd_rdata"}, bus.mem_rdata, e);
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    bus.mem_read = 1'b0;
    #1;
    check({t, ":post_pread"}, 32'(bus.pmem_read), 32'd0);
`else
    check({t, ":fill_resp"}, 32'(bus.mem_resp), 32'd0);
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    #1;
    check({t, ":resp"}, 32'(bus.mem_resp), 32'd1);
    check({t, ":rdata"}, bus.mem_rdata, e);
    check({t, ":post_pread"}, 32'(bus.pmem_read), 32'd0);
`endif
    @(negedge clk);
    bus.mem_read = 1'b0;
  endtask

  initial begin
    bus.mem_address = '0;
    bus.mem_read = 1'b0;
    bus.pmem_rdata = '0;
    bus.pmem_resp = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst:resp", 32'(bus.mem_resp), 32'd0);
    check("rst:pread", 32'(bus.pmem_read), 32'd0);
    check("rst:paddr", bus.pmem_address, 32'd0);
    check("rst:rdata", bus.mem_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // cold miss, then hit in the same line
    miss_fill(32'h60, 4, 32'hA500_0060, "cold");
    hit_read(32'h64, 32'hA500_0064, "hit64");

    // LRU: B to way 1, touch A, C evicts B
    miss_fill(32'h160, 2, 32'hA500_0160, "fillB");
    hit_read(32'h68, 32'hA500_0068, "touchA");
    miss_fill(32'h264, 3, 32'hA500_0264, "fillC");
    hit_read(32'h6C, 32'hA500_006C, "reA");
    hit_read(32'h270, 32'hA500_0270, "reC");
    miss_fill(32'h160, 1, 32'hA500_0160, "reB");

    // pmem_resp while idle is ignored
    @(negedge clk);
    bus.pmem_resp = 1'b1;
    bus.pmem_rdata = '1;
    #1;
    check("idle_presp:resp", 32'(bus.mem_resp), 32'd0);
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    hit_read(32'h178, 32'hA500_0178, "idle_presp:hitB");

    // abandoned fill
    @(negedge clk);
    bus.mem_address = 32'h84;
    bus.mem_read = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.mem_read = 1'b0;
    bus.mem_address = 32'h3C0;
    @(negedge clk);
    @(negedge clk);
    bus.pmem_resp = 1'b1;
    bus.pmem_rdata = line_of(32'h80);
    #1;
    check("abandon:pread", 32'(bus.pmem_read), 32'd1);
    check("abandon:paddr", bus.pmem_address, 32'h80);
    check("abandon:resp0", 32'(bus.mem_resp), 32'd0);
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    #1;
    check("abandon:resp1", 32'(bus.mem_resp), 32'd0);
    check("abandon:idle", 32'(bus.pmem_read), 32'd0);
    hit_read(32'h9C, 32'hA500_009C, "abandon:hit");

    // reset in the middle of a fill
    @(negedge clk);
    bus.mem_address = 32'hA0;
    bus.mem_read = 1'b1;
    @(negedge clk);
    #1;
    check("rstfill:pread", 32'(bus.pmem_read), 32'd1);
    bus.mem_read = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rstfill:pread_off", 32'(bus.pmem_read), 32'd0);
    @(negedge clk);
    bus.pmem_resp = 1'b1;
    bus.pmem_rdata = line_of(32'hA0);
    #1;
    check("rstfill:stale_resp", 32'(bus.mem_resp), 32'd0);
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    #1;
    check("rstfill:stale_pread", 32'(bus.pmem_read), 32'd0);
    miss_fill(32'hA0, 2, 32'hA500_00A0, "rstfill:remiss");

    // A was valid before the reset; it must miss now
    miss_fill(32'h7C, 3, 32'hA500_007C, "fwd7C");
    hit_read(32'h60, 32'hA500_0060, "after:hitA");

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
